// File: rtl/perm_engine_if.sv
// Data-side valid/ready bundle for the bit-permutation engine.
// The master drives words in and accepts results; the slave is the engine.
interface perm_engine_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_inv;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/perm_engine.sv
// Runtime-programmable bit permutation (gather/scatter) with a single output register.
// Positions are MSB-first; the table resets to the DES P-box or identity.
module perm_engine #(
    parameter int WIDTH       = 32,
    parameter int IDXW        = $clog2(WIDTH),
    parameter bit DES_DEFAULT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    perm_engine_if.slave    bus,
    input  logic            cfg_we,
    input  logic [IDXW-1:0] cfg_idx,
    input  logic [IDXW-1:0] cfg_src,
    input  logic            cfg_restore,
    output logic            cfg_err
);

    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam int DES_P [32] = '{15, 6, 19, 20, 28, 11, 27, 16,
                                  0, 14, 22, 25,  4, 17, 30,  9,
                                  1,  7, 23, 13, 31, 26,  2,  8,
                                  18, 12, 29,  5, 21, 10,  3, 24};

    logic [IDXW-1:0]  tbl [WIDTH];
    logic [WIDTH-1:0] perm;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic             in_ready;
    logic             accept;
    logic             cfg_bad;

    function automatic logic [IDXW-1:0] dflt(input int k);
        if (DES_DEFAULT && WIDTH == 32)
            return IDXW'(DES_P[k % 32]);
        else
            return IDXW'(k);
    endfunction

    assign in_ready      = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    assign cfg_bad = (int'(cfg_idx) >= WIDTH) || (int'(cfg_src) >= WIDTH);

    // Scatter walks k upward so a later entry overwrites an earlier one on collision.
    always_comb begin
        perm = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (!bus.in_inv)
                perm[PW'(WIDTH-1-k)] = bus.in_data[PW'(WIDTH-1-int'(tbl[k]))];
            else
                perm[PW'(WIDTH-1-int'(tbl[k]))] = bus.in_data[PW'(WIDTH-1-k)];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cfg_err     <= 1'b0;
            for (int k = 0; k < WIDTH; k++)
                tbl[k] <= dflt(k);
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= perm;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            // perm above already used the pre-edge table, so same-edge writes affect later words only.
            if (cfg_restore) begin
                cfg_err <= 1'b0;
                for (int k = 0; k < WIDTH; k++)
                    tbl[k] <= dflt(k);
            end else if (cfg_we) begin
                if (cfg_bad)
                    cfg_err <= 1'b1;
                else
                    tbl[PW'(cfg_idx)] <= cfg_src;
            end
        end
    end

endmodule

// File: tb/tb_perm_engine.sv
// Scoreboard bench for perm_engine: driver queues hand-computed results,
// a negedge monitor pops and compares every completed output transfer.
module tb_perm_engine;

    localparam int WIDTH = 32;
    localparam int IDXW  = 6;

    logic            clk;
    logic            rst_n;
    logic            cfg_we;
    logic [IDXW-1:0] cfg_idx;
    logic [IDXW-1:0] cfg_src;
    logic            cfg_restore;
    logic            cfg_err;

    perm_engine_if #(.WIDTH(WIDTH)) bus ();

    perm_engine #(.WIDTH(WIDTH), .IDXW(IDXW), .DES_DEFAULT(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_src     (cfg_src),
        .cfg_restore (cfg_restore),
        .cfg_err     (cfg_err)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_output: got 0x%08h, expected no output", bus.out_data);
            end else begin
                check("out_data", bus.out_data, exp_q.pop_front());
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send_word(input logic [31:0] d, input logic inv, input logic [31:0] e,
                             output int waited);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_inv   = inv;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got in_ready=0 after %0d cycles, expected 1", n);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        waited = n;
    endtask

    task automatic cfg_write(input int idx, input int src);
        cfg_we  = 1'b1;
        cfg_idx = IDXW'(idx);
        cfg_src = IDXW'(src);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic restore();
        cfg_restore = 1'b1;
        @(posedge clk);
        #1;
        cfg_restore = 1'b0;
    endtask

    task automatic load_identity();
        for (int k = 0; k < WIDTH; k++)
            cfg_write(k, k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        rst_n        = 1'b0;
        cfg_we       = 1'b0;
        cfg_idx      = '0;
        cfg_src      = '0;
        cfg_restore  = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_inv   = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_data",  bus.out_data,       32'h0);
        check("rst_cfg_err",   32'(cfg_err),       32'h0);
        check("rst_in_ready",  32'(bus.in_ready),  32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // DES P forward/inverse
        send_word(32'h8000_0000, 1'b0, 32'h0080_0000, w);
        send_word(32'h0000_0001, 1'b0, 32'h0000_0800, w);
        send_word(32'h0080_0000, 1'b1, 32'h8000_0000, w);
        send_word(32'hDEAD_BEEF, 1'b0, 32'hF9BA_9DFF, w);
        send_word(32'hF9BA_9DFF, 1'b1, 32'hDEAD_BEEF, w);

        // identity, then restore colliding with a write
        load_identity();
        send_word(32'h1234_5678, 1'b0, 32'h1234_5678, w);
        send_word(32'h1234_5678, 1'b1, 32'h1234_5678, w);
        cfg_we  = 1'b1;
        cfg_idx = 6'd8;
        cfg_src = 6'd3;
        restore();
        cfg_we  = 1'b0;
        send_word(32'h8000_0000, 1'b0, 32'h0080_0000, w);

        // table write on the same edge as an accept
        load_identity();
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h8000_0000;
        bus.in_inv   = 1'b0;
        cfg_we  = 1'b1;
        cfg_idx = 6'd0;
        cfg_src = 6'd31;
        @(negedge clk);
        check("same_edge_ready", 32'(bus.in_ready), 32'h1);
        exp_q.push_back(32'h8000_0000);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        cfg_we = 1'b0;
        send_word(32'h0000_0001, 1'b0, 32'h8000_0001, w);
        send_word(32'h8000_0000, 1'b1, 32'h0000_0000, w);
        restore();

        // backpressure: stall 3 cycles after the first of four words
        send_word(32'h8000_0000, 1'b0, 32'h0080_0000, w);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0000_0001;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_in_ready",  32'(bus.in_ready),  32'h0);
            check("stall_out_valid", 32'(bus.out_valid), 32'h1);
            check("stall_out_data",  bus.out_data,       32'h0080_0000);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send_word(32'h0000_0001, 1'b0, 32'h0000_0800, w);
        check("resume_wait_w2", 32'(w), 32'h0);
        send_word(32'hDEAD_BEEF, 1'b0, 32'hF9BA_9DFF, w);
        check("resume_wait_w3", 32'(w), 32'h0);
        send_word(32'h0080_0000, 1'b0, 32'h0000_0100, w);
        check("resume_wait_w4", 32'(w), 32'h0);

        // out-of-range writes
        cfg_write(8, 40);
        @(negedge clk);
        check("err_src_set", 32'(cfg_err), 32'h1);
        @(posedge clk);
        #1;
        cfg_write(33, 0);
        send_word(32'h8000_0000, 1'b0, 32'h0080_0000, w);
        check("err_sticky", 32'(cfg_err), 32'h1);
        restore();
        check("err_restore_clr", 32'(cfg_err), 32'h0);
        cfg_write(8, 40);
        cfg_write(8, 3);
        send_word(32'h1000_0000, 1'b0, 32'h0080_0002, w);

        // reset with an output pending under backpressure
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0000_0001;
        bus.in_inv    = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_valid", 32'(bus.out_valid), 32'h1);
        check("pre_reset_err",   32'(cfg_err),       32'h1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_valid", 32'(bus.out_valid), 32'h0);
        check("post_reset_err",   32'(cfg_err),       32'h0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send_word(32'h8000_0000, 1'b0, 32'h0080_0000, w);
        send_word(32'h1000_0000, 1'b0, 32'h0000_0002, w);

        for (int c = 0; c < 20 && exp_q.size() != 0; c++)
            @(negedge clk);
        check("drain_remaining", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/perm_engine.md
Name: perm_engine

Overview:
- Parametrised, pipelined bit-permutation engine. It is the configurable successor to the fixed DES P-box.
- Permutes a WIDTH-bit word through a runtime-loadable index table. Supports a forward (gather) mode and an inverse (scatter) mode.
- Uses valid/ready handshakes on both the data input and the data output.
- Sits in the DES datapath after the S-box stage. Reset loads the DES P table, so it drops in as a P-box; the table can be reprogrammed for E/IP/FP or for test.

Parameters:
- WIDTH, 32, data word width in bits (≥2).
- IDXW, $clog2(WIDTH), width of a table index.
- DES_DEFAULT, 1: reset/restore loads the DES P table (requires WIDTH=32). If 0, loads the identity table.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  engine can accept a word.
- in_data  in  WIDTH  input word.
- in_inv  in  1  per-word mode: 0=forward, 1=inverse.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  WIDTH  permuted word.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  IDXW  table entry to write.
- cfg_src  in  IDXW  source position stored at cfg_idx.
- cfg_restore  in  1  reload the default table.
- cfg_err  out  1  sticky: a write had an out-of-range idx/src.

Behaviour:
- Bit numbering:
  - "Position p" means MSB-first: position 0 is bit WIDTH-1; position WIDTH-1 is bit 0.
  - The table T holds WIDTH entries of IDXW bits.
- Forward mode: output position k = input position T[k], for all k.
- Inverse mode: output position T[k] = input position k.
  - Entries are scattered in ascending k, so on a collision the higher k wins.
  - Output positions that no entry targets are 0.
  - When T is a bijection, inverse mode exactly undoes forward mode.
- DES P default table, T[0..31] = 15,6,19,20,28,11,27,16,0,14,22,25,4,17,30,9,1,7,23,13,31,26,2,8,18,12,29,5,21,10,3,24.
- Identity table: T[k]=k.
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, out_data=0, cfg_err=0.
  - T = default table.
  - in_ready reads 1 in the first cycle after reset.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational). This gives one output register with no bubble.
  - An input is accepted when in_valid && in_ready. The result is registered into out_data and out_valid=1 on the same edge.
  - Latency is 1 cycle. Full throughput is one word per cycle while out_ready=1.
  - out_valid && !out_ready: out_data and out_valid hold stable and in_ready=0. The input side must hold its word.
  - out_valid && out_ready with no new accept: out_valid→0 next cycle; out_data keeps its last value.
- Table writes:
  - cfg_we writes T[cfg_idx] ← cfg_src at the edge. The new value is used by words accepted on later edges.
  - A write and an accept on the same edge: the accepted word uses the old table.
  - Writes are allowed at any time and never stall data flow.
- Out-of-range writes:
  - If cfg_idx ≥ WIDTH or cfg_src ≥ WIDTH, the write is dropped and cfg_err is set.
  - cfg_err clears only on reset or cfg_restore.
- cfg_restore:
  - Reloads the default table and clears cfg_err.
  - If it coincides with cfg_we, restore wins and the write is dropped.
  - Words accepted on the same edge use the old table.
- Reset mid-operation: any pending output is discarded (out_valid=0) and the table returns to default.

Test Plan:
- Reset, then forward 0x80000000 with out_ready=1 → one cycle later out_valid=1, out_data=0x00800000. Forward 0x00000001 → 0x00000800.
- Inverse 0x00800000 → 0x80000000. Stream forward then inverse of 0xDEADBEEF → second result equals 0xDEADBEEF.
- Write T[k]=k for k=0..31, then forward 0x12345678 → 0x12345678. Issue cfg_restore, then forward 0x80000000 → 0x00800000.
- Table update same edge as accept:
  - With identity loaded, in the same edge accept 0x80000000 and write T[0]=31.
  - That word → 0x80000000; the next word 0x00000001 → 0x80000001.
- Backpressure: 4 back-to-back words with out_ready low for 3 cycles after the first.
  - in_ready=0 and out_data held for those 3 cycles.
  - No word lost or duplicated; order preserved; throughput returns to 1/cycle.
- Errors and reset:
  - Write cfg_src=40 (out of range for WIDTH=32) → cfg_err=1 and table unchanged.
  - Assert rst_n=0 while out_valid=1 and out_ready=0 → next cycle out_valid=0, cfg_err=0, DES table restored.
